// File: rtl/sha256_round_engine.sv
// Iterative SHA-256 compression: one 512-bit block in 64 single-cycle rounds, K[t] read from an external ROM.
// Optional feature: define SHA256_ROUND_ABORT_EN to add an `abort` input that cancels a block in flight.
module sha256_round_engine #(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [511:0] block_in,
  input  logic [255:0] hash_in,
  output logic [5:0]   k_addr,
  input  logic [31:0]  k_value,
`ifdef SHA256_ROUND_ABORT_EN
  input  logic         abort,
`endif
  output logic         busy,
  output logic         done,
  output logic [255:0] hash_out
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] FINAL = 2'd2;
  localparam logic [5:0] LAST  = 6'(ROUNDS - 1);

  logic [1:0]  state;
  logic [5:0]  t;
  logic [31:0] v  [8];
  logic [31:0] hs [8];
  logic [31:0] w  [16];

  logic [31:0]  t1, t2, w_next, ch, maj;
  logic [255:0] digest_next;
  logic         abort_hit;
  logic         accept;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

`ifdef SHA256_ROUND_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  // An abort coinciding with start in IDLE suppresses the start.
  assign accept = start && !abort_hit;

  assign ch     = (v[4] & v[5]) ^ (~v[4] & v[6]);
  assign maj    = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
  assign t1     = v[7] + big_sigma1(v[4]) + ch + k_value + w[0];
  assign t2     = big_sigma0(v[0]) + maj;
  assign w_next = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];

  assign busy   = (state != IDLE);
  assign k_addr = (state == ROUND) ? t : 6'd0;

  always_comb begin
    digest_next = '0;
    for (int i = 0; i < 8; i++) begin
      digest_next[255 - 32*i -: 32] = hs[i] + v[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      t        <= 6'd0;
      done     <= 1'b0;
      hash_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state <= ROUND;
            t     <= 6'd0;
          end
        end
        ROUND: begin
          if (abort_hit) begin
            state <= IDLE;
          end else begin
            t <= t + 6'd1;
            if (t == LAST) state <= FINAL;
          end
        end
        FINAL: begin
          state <= IDLE;
          if (!abort_hit) begin
            hash_out <= digest_next;
            done     <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath registers need no reset: they are always reloaded when a block is accepted.
  always_ff @(posedge clk) begin
    if (state == IDLE && accept) begin
      for (int i = 0; i < 16; i++) w[i] <= block_in[511 - 32*i -: 32];
      for (int i = 0; i < 8; i++) begin
        v[i]  <= hash_in[255 - 32*i -: 32];
        hs[i] <= hash_in[255 - 32*i -: 32];
      end
    end else if (state == ROUND) begin
      for (int i = 0; i < 15; i++) w[i] <= w[i+1];
      w[15] <= w_next;
      v[7]  <= v[6];
      v[6]  <= v[5];
      v[5]  <= v[4];
      v[4]  <= v[3] + t1;
      v[3]  <= v[2];
      v[2]  <= v[1];
      v[1]  <= v[0];
      v[0]  <= t1 + t2;
    end
  end

endmodule

// File: tb/tb_sha256_round_engine.sv
// Directed bench for sha256_round_engine: known digests, k_addr/busy/done timing, back-to-back, reset and abort.
module tb_sha256_round_engine;

  localparam logic [511:0] ABC_BLOCK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLOCK = {32'h80000000, 480'h0};
  localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] ABC_DIGEST   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] EMPTY_DIGEST = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [511:0] block_in = '0;
  logic [255:0] hash_in = '0;
  logic [5:0]   k_addr;
  logic [31:0]  k_value;
  logic         busy;
  logic         done;
  logic [255:0] hash_out;
`ifdef SHA256_ROUND_ABORT_EN
  logic         abort = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;
  logic [255:0] prev_digest = '0;

  assign k_value = K_ROM[k_addr];

  always #5 clk = ~clk;

  sha256_round_engine #(.ROUNDS(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .block_in (block_in),
    .hash_in  (hash_in),
    .k_addr   (k_addr),
    .k_value  (k_value),
`ifdef SHA256_ROUND_ABORT_EN
    .abort    (abort),
`endif
    .busy     (busy),
    .done     (done),
    .hash_out (hash_out)
  );

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic go, input logic [511:0] blk, input logic [255:0] hv);
    start    = go;
    block_in = blk;
    hash_in  = hv;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts a block in the current cycle and checks every cycle up to and including its done cycle.
  task automatic run_block(input logic [511:0] blk, input logic [255:0] hv,
                           input logic [255:0] exp_digest, input bit poke_mid);
    applyStimulus(1'b1, blk, hv);
    checkOutput("idle_k_addr", 256'(k_addr), 256'd0);
    step();
    applyStimulus(1'b0, {16{$urandom}}, {8{$urandom}});
    for (int c = 1; c <= 66; c++) begin
      checkOutput($sformatf("k_addr@%0d", c), 256'(k_addr), (c <= 64) ? 256'(c - 1) : 256'd0);
      checkOutput($sformatf("busy@%0d", c), 256'(busy), 256'(c <= 65));
      checkOutput($sformatf("done@%0d", c), 256'(done), 256'(c == 66));
      if (c == 65) checkOutput("hash_hold", hash_out, prev_digest);
      if (c == 66) checkOutput("digest", hash_out, exp_digest);
      if (poke_mid && c == 20) applyStimulus(1'b1, {16{32'hdeadbeef}}, {8{32'h12345678}});
      if (poke_mid && c == 21) start = 1'b0;
      if (c < 66) step();
    end
    prev_digest = exp_digest;
  endtask

  // Runs "abc" and asserts reset together with start during round 30, then confirms silence.
  task automatic run_reset_mid();
    applyStimulus(1'b1, ABC_BLOCK, IV);
    step();
    applyStimulus(1'b0, '0, '0);
    for (int c = 1; c < 31; c++) step();
    checkOutput("k_addr_round30", 256'(k_addr), 256'd30);
    rst   = 1'b1;
    start = 1'b1;
    step();
    rst   = 1'b0;
    start = 1'b0;
    checkOutput("rst_busy", 256'(busy), 256'd0);
    checkOutput("rst_done", 256'(done), 256'd0);
    checkOutput("rst_k_addr", 256'(k_addr), 256'd0);
    checkOutput("rst_hash", hash_out, 256'd0);
    prev_digest = '0;
    for (int c = 0; c < 70; c++) begin
      step();
      checkOutput("rst_no_done", 256'(done), 256'd0);
    end
  endtask

`ifdef SHA256_ROUND_ABORT_EN
  task automatic run_abort_mid();
    abort = 1'b1;
    applyStimulus(1'b1, ABC_BLOCK, IV);
    step();
    abort = 1'b0;
    applyStimulus(1'b0, '0, '0);
    checkOutput("abort_start_ignored", 256'(busy), 256'd0);
    applyStimulus(1'b1, EMPTY_BLOCK, IV);
    step();
    applyStimulus(1'b0, '0, '0);
    for (int c = 1; c < 11; c++) step();
    checkOutput("k_addr_round10", 256'(k_addr), 256'd10);
    abort = 1'b1;
    step();
    abort = 1'b0;
    checkOutput("abort_busy", 256'(busy), 256'd0);
    checkOutput("abort_done", 256'(done), 256'd0);
    checkOutput("abort_hash", hash_out, ABC_DIGEST);
    for (int c = 0; c < 70; c++) begin
      step();
      checkOutput("abort_no_done", 256'(done), 256'd0);
    end
    checkOutput("abort_hash_final", hash_out, ABC_DIGEST);
  endtask
`endif

  initial begin
    step();
    step();
    checkOutput("reset_busy", 256'(busy), 256'd0);
    checkOutput("reset_done", 256'(done), 256'd0);
    checkOutput("reset_hash", hash_out, 256'd0);
    checkOutput("reset_k_addr", 256'(k_addr), 256'd0);
    rst = 1'b0;
    step();
    checkOutput("idle_busy", 256'(busy), 256'd0);

    run_block(ABC_BLOCK, IV, ABC_DIGEST, 1'b0);
    run_block(EMPTY_BLOCK, IV, EMPTY_DIGEST, 1'b1);
    step();
    checkOutput("post_done_low", 256'(done), 256'd0);
    checkOutput("post_hash_held", hash_out, EMPTY_DIGEST);

    run_reset_mid();
    run_block(ABC_BLOCK, IV, ABC_DIGEST, 1'b0);
    step();
`ifdef SHA256_ROUND_ABORT_EN
    run_abort_mid();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
